// File: rtl/spi_lcd_rx.sv
// spi_lcd_rx: SPI receiver for an LCD-style command/data stream.
// Reassembles bytes from an asynchronous SPI link, tracks the CASET/PASET
// window and the RAMWR cursor, and emits one RGB565 pixel per data pair.
// Optional build macro: SPI_LCD_RX_BOUNDS_CHECK_EN enables window and pixel
// range checking with a sticky o_err. Without it, o_err is tied low.
module spi_lcd_rx #(
   parameter int WIDTH  = 240,
   parameter int HEIGHT = 320
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_sclk,
   input  logic        i_mosi,
   input  logic        i_dc,
   input  logic        i_cs,
   output logic        o_cmd_valid,
   output logic [7:0]  o_cmd,
   output logic        o_pix_valid,
   output logic [8:0]  o_pix_x,
   output logic [8:0]  o_pix_y,
   output logic [15:0] o_pix_data,
   output logic        o_err
);

   localparam logic [15:0] X_MAX = 16'(WIDTH - 1);
   localparam logic [15:0] Y_MAX = 16'(HEIGHT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CASET = 2'd1,
      PASET = 2'd2,
      RAMWR = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronisers and sclk edge detection
   // ------------------------------------------------------------------
   logic [1:0] sclk_sync_q;
   logic [1:0] mosi_sync_q;
   logic [1:0] dc_sync_q;
   logic [1:0] cs_sync_q;
   logic       sclk_prev_q;

   logic sclk_s;
   logic mosi_s;
   logic dc_s;
   logic cs_s;
   logic sclk_rise;

   assign sclk_s    = sclk_sync_q[1];
   assign mosi_s    = mosi_sync_q[1];
   assign dc_s      = dc_sync_q[1];
   assign cs_s      = cs_sync_q[1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;

   // Two-flop synchronisers; reset to the bus idle levels so no false edge follows reset
   always_ff @(posedge i_clk) begin
      // NOTE: every clocked register uses <= so all flops update from pre-edge values.
      if (i_rst) begin
         sclk_sync_q <= 2'b00;
         mosi_sync_q <= 2'b00;
         dc_sync_q   <= 2'b00;
         cs_sync_q   <= 2'b11;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], i_sclk};
         mosi_sync_q <= {mosi_sync_q[0], i_mosi};
         dc_sync_q   <= {dc_sync_q[0], i_dc};
         cs_sync_q   <= {cs_sync_q[0], i_cs};
         sclk_prev_q <= sclk_s;
      end
   end

   // ------------------------------------------------------------------
   // Byte assembly: MSB first, byte event one cycle after the 8th edge
   // ------------------------------------------------------------------
   logic [7:0] shift_q;
   logic [2:0] bit_cnt_q;
   logic       byte_done_q;
   logic [7:0] byte_q;
   logic       byte_dc_q;

   // Shift bits in on each synchronised sclk rise; cs high drops any partial byte
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         shift_q     <= 8'h00;
         bit_cnt_q   <= 3'd0;
         byte_done_q <= 1'b0;
         byte_q      <= 8'h00;
         byte_dc_q   <= 1'b0;
      end else begin
         byte_done_q <= 1'b0;
         if (cs_s) begin
            bit_cnt_q <= 3'd0;
         end else if (sclk_rise) begin
            shift_q   <= {shift_q[6:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               byte_done_q <= 1'b1;
               byte_q      <= {shift_q[6:0], mosi_s};
               byte_dc_q   <= dc_s;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Decoder
   // ------------------------------------------------------------------
   state_t      state_q;
   logic [1:0]  prm_cnt_q;
   logic [23:0] prm_q;
   logic [7:0]  pix_hi_q;
   logic        pix_half_q;
   logic [15:0] sc_q;
   logic [15:0] ec_q;
   logic [15:0] sp_q;
   logic [15:0] ep_q;
   logic [15:0] cx_q;
   logic [15:0] cy_q;

   logic [15:0] win_lo_d;
   logic [15:0] win_hi_d;
   logic [15:0] cx_d;
   logic [15:0] cy_d;
   logic        pix_emit;

   // Window values as they will be committed by the 4th parameter byte, and the advanced cursor
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      win_lo_d = prm_q[23:8];
      win_hi_d = {prm_q[7:0], byte_q};
      cx_d     = cx_q + 16'd1;
      cy_d     = cy_q;
      if (cx_q == ec_q) begin
         cx_d = sc_q;
         cy_d = (cy_q == ep_q) ? sp_q : cy_q + 16'd1;
      end
   end

`ifdef SPI_LCD_RX_BOUNDS_CHECK_EN
   logic caset_commit;
   logic paset_commit;
   logic pix_fire;
   logic err_q;

   assign pix_emit     = (cx_q <= X_MAX) && (cy_q <= Y_MAX);
   assign caset_commit = byte_done_q && byte_dc_q && (state_q == CASET) && (prm_cnt_q == 2'd3);
   assign paset_commit = byte_done_q && byte_dc_q && (state_q == PASET) && (prm_cnt_q == 2'd3);
   assign pix_fire     = byte_done_q && byte_dc_q && (state_q == RAMWR) && pix_half_q;

   // Sticky error on a bad committed window or an out-of-panel pixel
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         err_q <= 1'b0;
      end else if ((caset_commit && ((win_lo_d > win_hi_d) || (win_hi_d > X_MAX))) ||
                   (paset_commit && ((win_lo_d > win_hi_d) || (win_hi_d > Y_MAX))) ||
                   (pix_fire && !pix_emit)) begin
         err_q <= 1'b1;
      end
   end

   assign o_err = err_q;
`else
   assign pix_emit = 1'b1;
   assign o_err    = 1'b0;
`endif

   // Command/parameter/pixel decoder with registered output pulses
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         prm_cnt_q   <= 2'd0;
         prm_q       <= 24'h000000;
         pix_hi_q    <= 8'h00;
         pix_half_q  <= 1'b0;
         sc_q        <= 16'h0000;
         ec_q        <= X_MAX;
         sp_q        <= 16'h0000;
         ep_q        <= Y_MAX;
         cx_q        <= 16'h0000;
         cy_q        <= 16'h0000;
         o_cmd_valid <= 1'b0;
         o_cmd       <= 8'h00;
         o_pix_valid <= 1'b0;
         o_pix_x     <= 9'd0;
         o_pix_y     <= 9'd0;
         o_pix_data  <= 16'h0000;
      end else begin
         o_cmd_valid <= 1'b0;
         o_pix_valid <= 1'b0;
         if (byte_done_q) begin
            if (!byte_dc_q) begin
               // A command always restarts parameter and pixel assembly
               o_cmd_valid <= 1'b1;
               o_cmd       <= byte_q;
               prm_cnt_q   <= 2'd0;
               pix_half_q  <= 1'b0;
               case (byte_q)
                  8'h2A:   state_q <= CASET;
                  8'h2B:   state_q <= PASET;
                  8'h2C: begin
                     state_q <= RAMWR;
                     cx_q    <= sc_q;
                     cy_q    <= sp_q;
                  end
                  default: state_q <= IDLE;
               endcase
            end else begin
               case (state_q)
                  CASET, PASET: begin
                     prm_q     <= {prm_q[15:0], byte_q};
                     prm_cnt_q <= prm_cnt_q + 2'd1;
                     if (prm_cnt_q == 2'd3) begin
                        if (state_q == CASET) begin
                           sc_q <= win_lo_d;
                           ec_q <= win_hi_d;
                        end else begin
                           sp_q <= win_lo_d;
                           ep_q <= win_hi_d;
                        end
                        state_q <= IDLE;
                     end
                  end
                  RAMWR: begin
                     if (!pix_half_q) begin
                        pix_hi_q   <= byte_q;
                        pix_half_q <= 1'b1;
                     end else begin
                        pix_half_q <= 1'b0;
                        cx_q       <= cx_d;
                        cy_q       <= cy_d;
                        if (pix_emit) begin
                           o_pix_valid <= 1'b1;
                           o_pix_x     <= cx_q[8:0];
                           o_pix_y     <= cy_q[8:0];
                           o_pix_data  <= {pix_hi_q, byte_q};
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_lcd_rx.sv
// tb_spi_lcd_rx: directed bench for spi_lcd_rx.
// Expectations follow SPI_LCD_RX_BOUNDS_CHECK_EN the same way the design does.
module tb_spi_lcd_rx;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_sclk = 1'b0;
   logic        i_mosi = 1'b0;
   logic        i_dc = 1'b0;
   logic        i_cs = 1'b1;
   logic        o_cmd_valid;
   logic [7:0]  o_cmd;
   logic        o_pix_valid;
   logic [8:0]  o_pix_x;
   logic [8:0]  o_pix_y;
   logic [15:0] o_pix_data;
   logic        o_err;

`ifdef SPI_LCD_RX_BOUNDS_CHECK_EN
   localparam logic BC = 1'b1;
`else
   localparam logic BC = 1'b0;
`endif

   typedef struct packed {
      logic [8:0]  x;
      logic [8:0]  y;
      logic [15:0] d;
   } pix_t;

   pix_t       pix_q[$];
   logic [7:0] cmd_q[$];
   int         overlap_cnt = 0;
   int         checks = 0;
   int         failures = 0;

   spi_lcd_rx #(.WIDTH(240), .HEIGHT(320)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_sclk      (i_sclk),
      .i_mosi      (i_mosi),
      .i_dc        (i_dc),
      .i_cs        (i_cs),
      .o_cmd_valid (o_cmd_valid),
      .o_cmd       (o_cmd),
      .o_pix_valid (o_pix_valid),
      .o_pix_x     (o_pix_x),
      .o_pix_y     (o_pix_y),
      .o_pix_data  (o_pix_data),
      .o_err       (o_err)
   );

   always #5 i_clk = ~i_clk;

   // Capture output pulses on the falling edge
   always @(negedge i_clk) begin
      if (o_pix_valid) pix_q.push_back('{x: o_pix_x, y: o_pix_y, d: o_pix_data});
      if (o_cmd_valid) cmd_q.push_back(o_cmd);
      if (o_pix_valid && o_cmd_valid) overlap_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic spi_byte(input logic [7:0] b, input logic dc);
      for (int i = 7; i >= 0; i--) begin
         @(negedge i_clk);
         i_sclk = 1'b0;
         i_mosi = b[i];
         i_dc   = dc;
         repeat (3) @(negedge i_clk);
         i_sclk = 1'b1;
         repeat (2) @(negedge i_clk);
      end
   endtask

   task automatic send_cmd(input logic [7:0] c);
      spi_byte(c, 1'b0);
   endtask

   task automatic send_data(input logic [7:0] d);
      spi_byte(d, 1'b1);
   endtask

   task automatic cs_on();
      @(negedge i_clk);
      i_cs = 1'b0;
      repeat (4) @(negedge i_clk);
   endtask

   task automatic cs_off();
      @(negedge i_clk);
      i_sclk = 1'b0;
      repeat (3) @(negedge i_clk);
      i_cs = 1'b1;
      repeat (6) @(negedge i_clk);
   endtask

   task automatic settle();
      @(negedge i_clk);
      i_sclk = 1'b0;
      repeat (12) @(negedge i_clk);
   endtask

   task automatic chk_pix(input string tag, input logic [8:0] x, input logic [8:0] y,
                          input logic [15:0] d);
      pix_t p;
      check({tag, "_avail"}, 32'(pix_q.size() > 0), 32'd1);
      if (pix_q.size() > 0) begin
         p = pix_q.pop_front();
         check({tag, "_x"}, 32'(p.x), 32'(x));
         check({tag, "_y"}, 32'(p.y), 32'(y));
         check({tag, "_d"}, 32'(p.d), 32'(d));
      end
   endtask

   task automatic chk_cmd(input string tag, input logic [7:0] c);
      check({tag, "_avail"}, 32'(cmd_q.size() > 0), 32'd1);
      if (cmd_q.size() > 0) check({tag, "_val"}, 32'(cmd_q.pop_front()), 32'(c));
   endtask

   initial begin
      logic [8:0] ey;

      // Reset state
      repeat (5) @(negedge i_clk);
      i_rst = 1'b0;
      repeat (3) @(negedge i_clk);
      check("rst_cmd_valid", 32'(o_cmd_valid), 32'd0);
      check("rst_cmd", 32'(o_cmd), 32'd0);
      check("rst_pix_valid", 32'(o_pix_valid), 32'd0);
      check("rst_pix_data", 32'(o_pix_data), 32'd0);
      check("rst_err", 32'(o_err), 32'd0);

      // CASET with full-width window: one command, no pixels
      cs_on();
      send_cmd(8'h2A);
      send_data(8'h00); send_data(8'h00); send_data(8'h00); send_data(8'hEF);
      settle();
      check("caset_cmd_cnt", 32'(cmd_q.size()), 32'd1);
      chk_cmd("caset_cmd", 8'h2A);
      check("caset_no_pix", 32'(pix_q.size()), 32'd0);
      check("caset_err", 32'(o_err), 32'd0);

      // 2x2 window, four pixels
      send_cmd(8'h2A);
      send_data(8'h00); send_data(8'h00); send_data(8'h00); send_data(8'h01);
      send_cmd(8'h2B);
      send_data(8'h00); send_data(8'h00); send_data(8'h00); send_data(8'h01);
      send_cmd(8'h2C);
      send_data(8'h12); send_data(8'h34); send_data(8'h56); send_data(8'h78);
      send_data(8'h9A); send_data(8'hBC); send_data(8'hDE); send_data(8'hF0);
      settle();
      check("win_cmd_cnt", 32'(cmd_q.size()), 32'd3);
      chk_cmd("win_cmd0", 8'h2A);
      chk_cmd("win_cmd1", 8'h2B);
      chk_cmd("win_cmd2", 8'h2C);
      check("win_pix_cnt", 32'(pix_q.size()), 32'd4);
      chk_pix("p0", 9'd0, 9'd0, 16'h1234);
      chk_pix("p1", 9'd1, 9'd0, 16'h5678);
      chk_pix("p2", 9'd0, 9'd1, 16'h9ABC);
      chk_pix("p3", 9'd1, 9'd1, 16'hDEF0);

      // Page wrap back to origin
      send_data(8'hAA); send_data(8'h55);
      settle();
      check("wrap_pix_cnt", 32'(pix_q.size()), 32'd1);
      chk_pix("wrap", 9'd0, 9'd0, 16'hAA55);

      // cs drop after 5 bits discards the partial byte
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         i_sclk = 1'b0; i_mosi = 1'b1; i_dc = 1'b1;
         repeat (3) @(negedge i_clk);
         i_sclk = 1'b1;
         repeat (2) @(negedge i_clk);
      end
      cs_off();
      cs_on();
      send_cmd(8'h2C);
      settle();
      check("csdrop_cmd_cnt", 32'(cmd_q.size()), 32'd1);
      chk_cmd("csdrop_cmd", 8'h2C);
      check("csdrop_no_pix", 32'(pix_q.size()), 32'd0);
      send_data(8'h11); send_data(8'h22);
      settle();
      chk_pix("csdrop_pix", 9'd0, 9'd0, 16'h1122);

      // Out-of-panel page window
      send_cmd(8'h2B);
      send_data(8'h00); send_data(8'h08); send_data(8'h01); send_data(8'h47);
      settle();
      check("bounds_err", 32'(o_err), 32'(BC));
      send_cmd(8'h2B);
      send_data(8'h01); send_data(8'h3E); send_data(8'h01); send_data(8'h47);
      send_cmd(8'h2A);
      send_data(8'h00); send_data(8'h00); send_data(8'h00); send_data(8'h00);
      send_cmd(8'h2C);
      for (int i = 0; i < 11; i++) begin
         send_data(8'hC0);
         send_data(8'(i));
      end
      settle();
      cmd_q.delete();
      check("bounds_pix_cnt", 32'(pix_q.size()), BC ? 32'd3 : 32'd11);
      for (int i = 0; i < 11; i++) begin
         ey = 9'(318 + (i % 10));
         if (!(BC && ey > 9'd319)) chk_pix("bounds_pix", 9'd0, ey, {8'hC0, 8'(i)});
      end
      check("bounds_err_sticky", 32'(o_err), 32'(BC));

      // Reset during RAMWR after one pixel byte
      send_cmd(8'h2A);
      send_data(8'h00); send_data(8'h05); send_data(8'h00); send_data(8'h05);
      send_cmd(8'h2B);
      send_data(8'h00); send_data(8'h07); send_data(8'h00); send_data(8'h07);
      send_cmd(8'h2C);
      send_data(8'h77);
      @(negedge i_clk);
      i_sclk = 1'b0;
      i_rst  = 1'b1;
      repeat (4) @(negedge i_clk);
      i_rst = 1'b0;
      check("mrst_cmd", 32'(o_cmd), 32'd0);
      check("mrst_err", 32'(o_err), 32'd0);
      send_data(8'h88);
      settle();
      check("mrst_no_pix", 32'(pix_q.size()), 32'd0);
      check("mrst_cmd_cnt", 32'(cmd_q.size()), 32'd3);
      cmd_q.delete();
      send_cmd(8'h2C);
      send_data(8'h01); send_data(8'h02); send_data(8'h03); send_data(8'h04);
      settle();
      check("mrst_pix_cnt", 32'(pix_q.size()), 32'd2);
      chk_pix("mrst_p0", 9'd0, 9'd0, 16'h0102);
      chk_pix("mrst_p1", 9'd1, 9'd0, 16'h0304);
      cs_off();

      check("no_overlap", 32'(overlap_cnt), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_lcd_rx.md
SPI_LCD_RX -- requirements
Module: spi_lcd_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 240, panel column count.
REQ-002 SHALL have parameter HEIGHT, default 320, panel row count.
REQ-003 i_clk  input  1  system clock; all logic on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_sclk  input  1  SPI clock from master; asynchronous to i_clk.
REQ-006 i_mosi  input  1  serial data, MSB first, sampled on i_sclk rising edge.
REQ-007 i_dc  input  1  0 = command byte, 1 = data byte; sampled with bit 0.
REQ-008 i_cs  input  1  chip select, active-low.
REQ-009 o_cmd_valid  output  1  one-cycle pulse on each received command byte.
REQ-010 o_cmd  output  8  last command byte; valid while o_cmd_valid is high.
REQ-011 o_pix_valid  output  1  one-cycle pulse per decoded RGB565 pixel.
REQ-012 o_pix_x  output  9  pixel column.
REQ-013 o_pix_y  output  9  pixel row.
REQ-014 o_pix_data  output  16  pixel colour, first byte in [15:8].
REQ-015 o_err  output  1  sticky error flag.

Function
REQ-016 i_sclk, i_mosi, i_dc, i_cs SHALL each pass through a 2-flop synchroniser; i_sclk high and low phases SHALL each be at least 3 i_clk cycles.
REQ-017 A rising edge of synchronised sclk with synchronised cs low SHALL shift mosi into the byte register and increment a 3-bit bit counter.
REQ-018 On the 8th bit the byte and the dc sampled with that bit SHALL complete; the byte event SHALL occur 1 cycle after the edge is detected.
REQ-019 Synchronised cs high SHALL clear the bit counter and discard partial bits; decoder state SHALL be kept.
REQ-020 Decoder states: IDLE, CASET, PASET, RAMWR.
REQ-021 A command byte SHALL pulse o_cmd_valid and update o_cmd in every state, abandon any partial parameter sequence or pixel byte, then: 8'h2A -> CASET, 8'h2B -> PASET, 8'h2C -> RAMWR with cursor x = SC, y = SP, any other -> IDLE.
REQ-022 CASET SHALL collect 4 data bytes as SC[15:8], SC[7:0], EC[15:8], EC[7:0], commit SC/EC only after byte 4, then go to IDLE; PASET does the same for SP/EP.
REQ-023 Data bytes in IDLE SHALL be ignored.
REQ-024 In RAMWR, data bytes SHALL pair into pixels; o_pix_valid SHALL pulse 1 cycle after the second byte completes, carrying the current cursor.
REQ-025 After each pixel the cursor SHALL advance: x++; when x == EC, x = SC and y++; when also y == EP, y = SP.
REQ-026 o_pix_x/o_pix_y SHALL be the low 9 bits of the 16-bit cursor.
REQ-027 o_cmd_valid and o_pix_valid SHALL never be high in the same cycle.

Reset
REQ-028 On i_rst: outputs 0, state IDLE, bit counter 0, SC = 0, EC = WIDTH-1, SP = 0, EP = HEIGHT-1, cursor 0.
REQ-029 Reset mid-byte or mid-RAMWR SHALL discard all partial data; no pulse SHALL follow reset until a new complete byte arrives.

Configuration
REQ-030 Macro SPI_LCD_RX_BOUNDS_CHECK_EN defined: a committed SC > EC, EC > WIDTH-1, SP > EP, or EP > HEIGHT-1 SHALL set o_err; pixels with x > WIDTH-1 or y > HEIGHT-1 SHALL be suppressed (cursor still advances) and SHALL set o_err; o_err clears only on reset.
REQ-031 Macro undefined: no checks; o_err SHALL be tied 0; all pixels SHALL be emitted.

Verification
REQ-032 Send 2A with 00 00 00 EF -> o_cmd_valid with o_cmd = 8'h2A; SC = 0, EC = 239; no o_pix_valid.
REQ-033 Send 2A 00 00 00 01, 2B 00 00 00 01, 2C, then 8 data bytes 12 34 56 78 9A BC DE F0 -> 4 pixels (0,0,1234), (1,0,5678), (0,1,9ABC), (1,1,DEF0).
REQ-034 After REQ-033, send 2 more bytes AA 55 -> pixel (0,0,AA55) (page wrap).
REQ-035 Drop cs high after 5 bits of a data byte, then send a full byte 8'h2C with dc = 0 -> exactly one o_cmd_valid with 8'h2C; partial bits lost.
REQ-036 With SPI_LCD_RX_BOUNDS_CHECK_EN defined: send 2B with 00 08 01 47 (EP = 327) -> o_err = 1 after byte 4; in RAMWR, rows 320..327 emit no o_pix_valid. Without the macro, o_err stays 0.
REQ-037 Assert i_rst during RAMWR after 1 pixel byte, release, send 1 data byte -> no o_pix_valid; window reads back reset values.
